// File: rtl/rs485_pkg.sv
// Shared types and pin constants for the RS-485 transceiver sequencer bank.
package rs485_pkg;

  typedef enum logic [2:0] {
    PARK = 3'd0,
    RX   = 3'd1,
    PRE  = 3'd2,
    DATA = 3'd3,
    POST = 3'd4
  } chan_state_t;

  localparam logic PARK_D   = 1'b0;
  localparam logic PARK_NRE = 1'b1;
  localparam logic PARK_DE  = 1'b0;
  localparam logic IDLE_BIT = 1'b1;

  // True while the channel owns the bus (DE asserted).
  function automatic logic is_driving(input chan_state_t s);
    return (s == PRE) || (s == DATA) || (s == POST);
  endfunction

endpackage

// File: rtl/rs485_chan.sv
// One half-duplex RS-485 channel: direction-turnaround FSM, guard counter, tx bit register, rx synchroniser.
// Optional rx glitch filter selected by RS485_RX_FILTER_EN.
module rs485_chan
  import rs485_pkg::*;
#(
  parameter int GUARD_PRE  = 4,
  parameter int GUARD_POST = 4
`ifdef RS485_RX_FILTER_EN
  ,
  parameter int FILT_LEN   = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_en_i,
  input  logic       tx_req_i,
  input  logic       tx_d_i,
  output logic       tx_rdy_o,
  output logic       tx_abort_o,
  output logic       busy_o,
  output logic       line_d_o,
  output logic       line_nre_o,
  output logic       line_de_o,
  input  logic       line_r_i,
  output logic       rx_q_o,
  output logic [2:0] state_o
);

  localparam int GMAX = (GUARD_PRE > GUARD_POST) ? GUARD_PRE : GUARD_POST;
  localparam int CW   = $clog2(GMAX + 1);

  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_q, bit_d;
  logic          abort_d;
  logic          line_d_d, line_nre_d, line_de_d, rdy_d, busy_d;
  logic          line_d_q, line_nre_q, line_de_q, rdy_q, busy_q, abort_q;
  logic          sync1_q, sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    abort_d = 1'b0;
    if (!ch_en_i) begin
      state_d = PARK;
      abort_d = is_driving(state_q);
    end else begin
      case (state_q)
        PARK: state_d = RX;
        RX: begin
          if (tx_req_i) begin
            state_d = PRE;
            cnt_d   = CW'(GUARD_PRE - 1);
          end
        end
        PRE: begin
          if (cnt_q == '0) begin
            if (tx_req_i) begin
              state_d = DATA;
              bit_d   = IDLE_BIT;
            end else begin
              state_d = POST;
              cnt_d   = CW'(GUARD_POST - 1);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (!tx_req_i) begin
            state_d = POST;
            cnt_d   = CW'(GUARD_POST - 1);
          end else begin
            bit_d = tx_d_i;
          end
        end
        POST: begin
          if (cnt_q == '0) begin
            state_d = RX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = PARK;
      endcase
    end
  end

  // Pins are decoded from the next state so they leave the flops aligned with state_q.
  always_comb begin
    line_d_d   = PARK_D;
    line_nre_d = PARK_NRE;
    line_de_d  = PARK_DE;
    case (state_d)
      RX: begin
        line_d_d   = 1'b0;
        line_nre_d = 1'b0;
        line_de_d  = 1'b0;
      end
      PRE, POST: begin
        line_d_d   = IDLE_BIT;
        line_nre_d = 1'b1;
        line_de_d  = 1'b1;
      end
      DATA: begin
        line_d_d   = bit_d;
        line_nre_d = 1'b1;
        line_de_d  = 1'b1;
      end
      default: ;
    endcase
    rdy_d  = (state_d == DATA);
    busy_d = is_driving(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PARK;
      cnt_q      <= '0;
      bit_q      <= IDLE_BIT;
      line_d_q   <= PARK_D;
      line_nre_q <= PARK_NRE;
      line_de_q  <= PARK_DE;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      sync1_q    <= IDLE_BIT;
      sync2_q    <= IDLE_BIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      line_d_q   <= line_d_d;
      line_nre_q <= line_nre_d;
      line_de_q  <= line_de_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      sync1_q    <= line_r_i;
      sync2_q    <= sync1_q;
    end
  end

`ifdef RS485_RX_FILTER_EN
  logic [FILT_LEN-1:0] hist_q, hist_d;
  logic                filt_q, filt_d;

  // Output flips only once the whole window of synchronised samples agrees.
  always_comb begin
    hist_d = {hist_q[FILT_LEN-2:0], sync2_q};
    filt_d = filt_q;
    if (hist_d == '0) begin
      filt_d = 1'b0;
    end else if (&hist_d) begin
      filt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_d == RX && state_q != RX)) begin
      hist_q <= '1;
      filt_q <= IDLE_BIT;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign rx_q_o = (state_q == RX) ? filt_q : IDLE_BIT;
`else
  assign rx_q_o = (state_q == RX) ? sync2_q : IDLE_BIT;
`endif

  assign tx_rdy_o   = rdy_q;
  assign tx_abort_o = abort_q;
  assign busy_o     = busy_q;
  assign line_d_o   = line_d_q;
  assign line_nre_o = line_nre_q;
  assign line_de_o  = line_de_q;
  assign state_o    = state_q;

endmodule

// File: rtl/rs485_chan_bank.sv
// Bank of NCH independent RS-485 transceiver sequencers; state_dbg packs each channel's FSM state (3 bits each).
// Optional rx glitch filter selected by RS485_RX_FILTER_EN.
module rs485_chan_bank
  import rs485_pkg::*;
#(
  parameter int NCH        = 22,
  parameter int GUARD_PRE  = 4,
  parameter int GUARD_POST = 4
`ifdef RS485_RX_FILTER_EN
  ,
  parameter int FILT_LEN   = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   tx_req,
  input  logic [NCH-1:0]   tx_d,
  output logic [NCH-1:0]   tx_rdy,
  output logic [NCH-1:0]   tx_abort,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   line_d,
  output logic [NCH-1:0]   line_nre,
  output logic [NCH-1:0]   line_de,
  input  logic [NCH-1:0]   line_r,
  output logic [NCH-1:0]   rx_q,
  output logic [3*NCH-1:0] state_dbg
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rs485_chan #(
      .GUARD_PRE (GUARD_PRE),
      .GUARD_POST(GUARD_POST)
`ifdef RS485_RX_FILTER_EN
      ,
      .FILT_LEN  (FILT_LEN)
`endif
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .ch_en_i   (ch_en[i]),
      .tx_req_i  (tx_req[i]),
      .tx_d_i    (tx_d[i]),
      .tx_rdy_o  (tx_rdy[i]),
      .tx_abort_o(tx_abort[i]),
      .busy_o    (busy[i]),
      .line_d_o  (line_d[i]),
      .line_nre_o(line_nre[i]),
      .line_de_o (line_de[i]),
      .line_r_i  (line_r[i]),
      .rx_q_o    (rx_q[i]),
      .state_o   (state_dbg[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_rs485_chan_bank.sv
// Self-checking bench for rs485_chan_bank: turnaround timing, tx data scoreboard, abort, rx latency, reset mid-frame.
module tb_rs485_chan_bank;
  import rs485_pkg::*;

  localparam int NCH        = 22;
  localparam int GUARD_PRE  = 4;
  localparam int GUARD_POST = 3;
  localparam int FILT       = 3;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   ch_en, tx_req, tx_d, line_r;
  logic [NCH-1:0]   tx_rdy, tx_abort, busy, line_d, line_nre, line_de, rx_q;
  logic [3*NCH-1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic exp_q[$];

  rs485_chan_bank #(
    .NCH       (NCH),
    .GUARD_PRE (GUARD_PRE),
    .GUARD_POST(GUARD_POST)
`ifdef RS485_RX_FILTER_EN
    ,
    .FILT_LEN  (FILT)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .tx_req   (tx_req),
    .tx_d     (tx_d),
    .tx_rdy   (tx_rdy),
    .tx_abort (tx_abort),
    .busy     (busy),
    .line_d   (line_d),
    .line_nre (line_nre),
    .line_de  (line_de),
    .line_r   (line_r),
    .rx_q     (rx_q),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2:0] st(input int ch);
    return state_dbg[3*ch +: 3];
  endfunction

  task automatic check_line_d_sb(input int ch);
    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
    else check("tx_line_d", line_d[ch], exp_q.pop_front());
  endtask

  // driver: full frame from RX; bits are pushed to the scoreboard as they are driven
  task automatic tx_frame(input int ch, input int nbits, input logic [31:0] bits);
    tx_req[ch] = 1'b1;
    step();
    for (int i = 0; i < GUARD_PRE; i++) begin
      check("pre_state", st(ch), PRE);
      check("pre_de", line_de[ch], 1);
      check("pre_d", line_d[ch], 1);
      check("pre_rdy", tx_rdy[ch], 0);
      if (i == GUARD_PRE - 1) exp_q.push_back(IDLE_BIT);
      step();
    end
    for (int i = 0; i < nbits; i++) begin
      check("data_rdy", tx_rdy[ch], 1);
      check_line_d_sb(ch);
      tx_d[ch] = bits[i];
      exp_q.push_back(bits[i]);
      step();
    end
    check("data_rdy_last", tx_rdy[ch], 1);
    check_line_d_sb(ch);
    tx_req[ch] = 1'b0;
    tx_d[ch]   = 1'b0;
    step();
    for (int i = 0; i < GUARD_POST; i++) begin
      check("post_state", st(ch), POST);
      check("post_de_d", {line_de[ch], line_d[ch], busy[ch], tx_rdy[ch]}, 4'b1110);
      step();
    end
    check("rx_after_post", {line_d[ch], line_nre[ch], line_de[ch], busy[ch]}, 4'b0000);
    check("rx_state", st(ch), RX);
    check("sb_empty", exp_q.size(), 0);
  endtask

  // driver: one-cycle request, frame must collapse to PRE then POST
  task automatic pulse_frame(input int ch);
    tx_req[ch] = 1'b1;
    step();
    tx_req[ch] = 1'b0;
    for (int i = 0; i < GUARD_PRE; i++) begin
      check("pulse_pre", {st(ch), tx_rdy[ch], line_de[ch]}, {PRE, 1'b0, 1'b1});
      step();
    end
    for (int i = 0; i < GUARD_POST; i++) begin
      check("pulse_post", {st(ch), tx_rdy[ch], line_de[ch]}, {POST, 1'b0, 1'b1});
      step();
    end
    check("pulse_rx", {st(ch), line_de[ch], line_nre[ch]}, {RX, 1'b0, 1'b0});
  endtask

  // driver: low pulse of given length on line_r[ch], rx_q checked against the expected latency
  task automatic rx_pulse(input int ch, input int len);
    logic exp;
    for (int t = 0; t < 14; t++) begin
`ifdef RS485_RX_FILTER_EN
      exp = !((len >= FILT) && (t >= 2 + FILT) && (t < 2 + FILT + len));
`else
      exp = !((t >= 2) && (t < 2 + len));
`endif
      check($sformatf("rx_len%0d_t%0d", len, t), rx_q[ch], exp);
      line_r[ch] = (t < len) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  initial begin
    logic [NCH-1:0] vec;
    logic [31:0]    rbits;
    rst    = 1'b1;
    ch_en  = '0;
    tx_req = '0;
    tx_d   = '0;
    line_r = '1;
    repeat (5) step();
    check("rst_pins", {line_d, line_nre, line_de}, {{NCH{1'b0}}, {NCH{1'b1}}, {NCH{1'b0}}});
    check("rst_rx_q", rx_q, {NCH{1'b1}});
    check("rst_busy_rdy_abort", {busy, tx_rdy, tx_abort}, '0);
    check("rst_state", state_dbg, '0);
    rst = 1'b0;
    repeat (4) step();
    check("park_nre", line_nre, {NCH{1'b1}});
    ch_en = '1;
    step();
    check("en_nre", line_nre, '0);
    check("en_de", line_de, '0);
    check("en_state0", st(0), RX);
    repeat (8) step();

    tx_frame(0, 4, 32'b1101);
    check("others_idle", line_de[NCH-1:1], '0);
    step();
    pulse_frame(1);
    step();
    for (int k = 0; k < 6; k++) rbits[k] = 1'($urandom_range(0, 1));
    tx_frame(0, 6, rbits);

    // abort of channel 3 mid-DATA
    tx_req[3] = 1'b1;
    repeat (1 + GUARD_PRE) step();
    check("ch3_data", st(3), DATA);
    tx_d[3] = 1'b0;
    step();
    ch_en[3] = 1'b0;
    step();
    vec = '0;
    vec[3] = 1'b1;
    check("abort_vec", tx_abort, vec);
    check("abort_pins", {line_d[3], line_nre[3], line_de[3], busy[3]}, 4'b0100);
    check("abort_state", st(3), PARK);
    check("abort_others", {line_de[2:0], line_de[NCH-1:4]}, '0);
    tx_req[3] = 1'b0;
    ch_en[3]  = 1'b1;
    step();
    check("abort_pulse_end", tx_abort, '0);
    check("ch3_reenable", {st(3), line_nre[3]}, {RX, 1'b0});
    repeat (3) step();

    rx_pulse(5, 2);
    rx_pulse(5, 5);

    // all channels at once, then reset mid-DATA
    tx_req = '1;
    repeat (1 + GUARD_PRE) step();
    check("all_rdy", tx_rdy, {NCH{1'b1}});
    check("all_busy", busy, {NCH{1'b1}});
    for (int k = 0; k < 2; k++) begin
      tx_d = NCH'($urandom());
      step();
      check("all_line_d", line_d, tx_d);
    end
    rst = 1'b1;
    step();
    check("mid_rst_pins", {line_d, line_nre, line_de}, {{NCH{1'b0}}, {NCH{1'b1}}, {NCH{1'b0}}});
    check("mid_rst_abort", tx_abort, '0);
    check("mid_rst_busy", {busy, tx_rdy}, '0);
    check("mid_rst_state", state_dbg, '0);
    rst    = 1'b0;
    tx_req = '0;
    step();
    check("post_rst_rx", line_nre, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
